miriscv_instr_mem_responder: RTL and testbench

Responder end of the core's instruction-memory interface. Accepts one fetch request per cycle (req plus address) and returns the addressed 32-bit word with rvalid a fixed LATENCY cycles later, fully pipelined. Backed by a word-organised synchronous RAM. A separate load port preloads the program image before the core leaves boot. Sits between the fetch unit and on-chip instruction SRAM.

---
 rtl/miriscv_pkg.sv | 15 +
 rtl/miriscv_ram_1r1w.sv | 24 ++
 rtl/miriscv_instr_mem_responder.sv | 102 ++++++++++
 tb/tb_miriscv_instr_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// Shared core constants plus the address check used by the instruction memory.
package miriscv_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0); also used by fetch/decode bubble insertion.
  localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

  // Offset is relative to the memory base; wrap-around below base lands high and fails.
  function automatic logic imem_offset_legal(input logic [XLEN-1:0] off,
                                             input int unsigned     idx_w);
    return (off[1:0] == 2'b00) && ((off >> (idx_w + 32'd2)) == '0);
  endfunction

endpackage

// File: rtl/miriscv_ram_1r1w.sv
// Synchronous 1-read/1-write RAM, read-first on address collision, no reset.
module miriscv_ram_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a colliding read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/miriscv_instr_mem_responder.sv
// Instruction-memory responder: fixed-latency, fully pipelined fetch responses
// from a preloadable word RAM, with misaligned/out-of-range error reporting.
module miriscv_instr_mem_responder
  import miriscv_pkg::*;
#(
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0]   BASE_ADDR   = '0,
  parameter int                LATENCY     = 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  output logic            instr_err_o,
  input  logic            load_we_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic [XLEN-1:0] load_wdata_i,
  output logic            load_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] rd_off, ld_off;
  logic            rd_legal, ld_legal;
  logic [XLEN-1:0] ram_q;

  assign rd_off   = instr_addr_i - BASE_ADDR;
  assign ld_off   = load_addr_i - BASE_ADDR;
  assign rd_legal = imem_offset_legal(rd_off, IDX_W);
  assign ld_legal = imem_offset_legal(ld_off, IDX_W);

  miriscv_ram_1r1w #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk_i (clk_i),
    .re    (instr_req_i & rd_legal),
    .raddr (rd_off[2 +: IDX_W]),
    .rdata (ram_q),
    .we    (load_we_i & ld_legal),
    .waddr (ld_off[2 +: IDX_W]),
    .wdata (load_wdata_i)
  );

  // Valid/err travel alongside the RAM access; stage 1 lines up with ram_q.
  logic [LATENCY:1] vld_pipe, err_pipe;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[1] <= instr_req_i;
      err_pipe[1] <= instr_req_i & ~rd_legal;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
      end
    end
  end

  logic [XLEN-1:0] d1, fin_d, last_q;
  logic            fin_v;

  assign d1    = err_pipe[1] ? RV_NOP_INSTR : ram_q;
  assign fin_v = vld_pipe[LATENCY];

  if (LATENCY > 1) begin : g_dly
    logic [LATENCY:2][XLEN-1:0] dat_pipe;

    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        dat_pipe <= {(LATENCY-1){RV_NOP_INSTR}};
      end else begin
        dat_pipe[2] <= d1;
        for (int k = 3; k <= LATENCY; k++) dat_pipe[k] <= dat_pipe[k-1];
      end
    end

    assign fin_d = dat_pipe[LATENCY];
  end else begin : g_direct
    assign fin_d = d1;
  end

  // rdata holds the last delivered word across idle slots.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     last_q <= RV_NOP_INSTR;
    else if (fin_v) last_q <= fin_d;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                      load_err_o <= 1'b0;
    else if (load_we_i && !ld_legal) load_err_o <= 1'b1;
  end

  assign instr_rvalid_o = fin_v;
  assign instr_err_o    = fin_v & err_pipe[LATENCY];
  assign instr_rdata_o  = fin_v ? fin_d : last_q;

endmodule

// File: tb/tb_miriscv_instr_mem_responder.sv
// Three responders (differing base, depth, latency) driven by the same offsets,
// checked every cycle against a response-timeline model.
module tb_miriscv_instr_mem_responder;
  import miriscv_pkg::*;

  localparam int ND = 3;
  localparam logic [31:0] BASE_A [ND] = '{32'h0, 32'h0, 32'h8000_0000};
  localparam int          DEP_A  [ND] = '{4096, 4096, 256};
  localparam int          LAT_A  [ND] = '{1, 3, 2};

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] off = '0, loff = '0, wdata = '0;

  logic [ND-1:0]        rvalid, err, lerr;
  logic [ND-1:0][31:0]  rdata;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [31:0] ia, la;
    assign ia = off + BASE_A[g];
    assign la = loff + BASE_A[g];
    miriscv_instr_mem_responder #(
      .DEPTH_WORDS (DEP_A[g]),
      .BASE_ADDR   (BASE_A[g]),
      .LATENCY     (LAT_A[g])
    ) u_dut (
      .clk_i          (clk),
      .arst_i         (arst),
      .instr_req_i    (req),
      .instr_addr_i   (ia),
      .instr_rvalid_o (rvalid[g]),
      .instr_rdata_o  (rdata[g]),
      .instr_err_o    (err[g]),
      .load_we_i      (we),
      .load_addr_i    (la),
      .load_wdata_i   (wdata),
      .load_err_o     (lerr[g])
    );
  end

  // Model: responses scheduled onto a per-DUT timeline of clock edges.
  typedef struct packed { logic v; logic e; logic [31:0] d; } slot_t;
  slot_t       slot   [ND][8];
  logic [31:0] last_m [ND];
  logic        lerr_m [ND];
  logic [31:0] mem_m  [int];
  int          k_edge = 0;
  int          checks = 0, failures = 0;

  function automatic bit legal_f(input logic [31:0] o, input int d);
    return (o[1:0] == 2'b00) && ({32'b0, o} < 64'(DEP_A[d]) * 4);
  endfunction

  function automatic int key_f(input logic [31:0] o, input int d);
    return d * (1 << 20) + int'(o >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, k_edge);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 8; i++) slot[d][i] = '0;
      last_m[d] = RV_NOP_INSTR;
      lerr_m[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      slot_t s = slot[d][k_edge % 8];
      logic [31:0] exp_d = s.v ? s.d : last_m[d];
      chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(s.v));
      chk($sformatf("err%0d", d),    32'(err[d]),    32'(s.v & s.e));
      chk($sformatf("rdata%0d", d),  rdata[d],       exp_d);
      chk($sformatf("load_err%0d", d), 32'(lerr[d]), 32'(lerr_m[d]));
      if (s.v) last_m[d] = s.d;
      slot[d][k_edge % 8].v = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (arst) clear_model();
    else begin
      for (int d = 0; d < ND; d++) begin
        slot_t s = '0;
        s.v = req;
        s.e = !legal_f(off, d);
        s.d = RV_NOP_INSTR;
        if (req && !s.e) s.d = mem_m[key_f(off, d)];
        slot[d][(k_edge + LAT_A[d] - 1) % 8] = s;
      end
      if (we)
        for (int d = 0; d < ND; d++)
          if (legal_f(loff, d)) mem_m[key_f(loff, d)] = wdata;
          else                  lerr_m[d] = 1'b1;
    end
    @(negedge clk);
    check_all();
    k_edge++;
  endtask

  task automatic drive(input logic r, input logic [31:0] o, input logic w,
                       input logic [31:0] lo, input logic [31:0] wd);
    req = r; off = o; we = w; loff = lo; wdata = wd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic readback();
    for (int w = 0; w <= 16; w++) drive(1'b1, (w == 16) ? 32'h3FC : 32'(w * 4), 1'b0, 0, 0);
    idle(3);
  endtask

  initial begin
    logic [31:0] img [4];
    img = '{32'h00A00093, 32'h00108113, 32'h0000006F, 32'hDEADBEEF};
    clear_model();

    // Reset values, checked asynchronously then across edges
    @(negedge clk);
    arst = 1'b1;
    #1 check_all();
    tick();
    arst = 1'b0;
    idle(1);

    // Preload words 0..15 and word 255 (aliases the illegal load below in the small DUT)
    for (int w = 0; w < 16; w++)
      drive(1'b0, 0, 1'b1, 32'(w * 4),
            (w < 4) ? img[w] : (w == 4) ? 32'h2222_2222 : $urandom);
    drive(1'b0, 0, 1'b1, 32'h3FC, 32'h0BAD_F00D);

    // Back-to-back fetches
    drive(1'b1, 32'h0, 1'b0, 0, 0);
    chk("t1_word0", rdata[0], 32'h00A00093);
    drive(1'b1, 32'h4, 1'b0, 0, 0);
    drive(1'b1, 32'h8, 1'b0, 0, 0);
    drive(1'b1, 32'hC, 1'b0, 0, 0);
    chk("t1_word3", rdata[0], 32'hDEADBEEF);
    idle(3);

    // Misaligned, beyond depth, below base
    drive(1'b1, 32'h2, 1'b0, 0, 0);
    chk("t2_mis_err", 32'(err[0]), 32'h1);
    drive(1'b1, 32'h4000, 1'b0, 0, 0);
    chk("t2_oor_nop", rdata[0], RV_NOP_INSTR);
    drive(1'b1, 32'hFFFF_FFF0, 1'b0, 0, 0);
    idle(3);

    // Same-cycle read/write collision returns the old word
    drive(1'b1, 32'h10, 1'b1, 32'h10, 32'h1111_1111);
    chk("t3_old", rdata[0], 32'h2222_2222);
    drive(1'b1, 32'h10, 1'b0, 0, 0);
    chk("t3_new", rdata[0], 32'h1111_1111);
    idle(3);

    // Sparse request pattern 1,0,1,1
    drive(1'b1, 32'h4, 1'b0, 0, 0);
    drive(1'b0, 32'h8, 1'b0, 0, 0);
    drive(1'b1, 32'h8, 1'b0, 0, 0);
    drive(1'b1, 32'hC, 1'b0, 0, 0);
    idle(4);

    // Randomized traffic with occasional legal preload writes
    for (int i = 0; i < 300; i++) begin
      int c = $urandom_range(0, 9);
      int w = $urandom_range(0, 16);
      logic [31:0] o = (w == 16) ? 32'h3FC : 32'(w * 4);
      if (c == 7)      o = o + 32'($urandom_range(1, 3));
      else if (c == 8) o = 32'h4000 + 32'($urandom_range(0, 255) * 4);
      else if (c == 9) o = 32'hFFFF_FFF0;
      drive($urandom_range(0, 3) != 0, o, $urandom_range(0, 3) == 0,
            32'($urandom_range(0, 15) * 4), $urandom);
    end
    idle(4);

    // Reset with requests in flight
    drive(1'b1, 32'h0, 1'b0, 0, 0);
    drive(1'b1, 32'h4, 1'b0, 0, 0);
    drive(1'b1, 32'h8, 1'b0, 0, 0);
    arst = 1'b1;
    #1 clear_model();
    check_all();
    req = 1'b1; off = 32'hC;
    tick();
    arst = 1'b0;
    idle(4);
    readback();

    // Illegal preload is sticky and writes nothing; later legal load keeps the flag
    drive(1'b0, 0, 1'b1, 32'h7FFF_FFFC, 32'hCAFE_CAFE);
    chk("t6_lerr_big", 32'(lerr[2]), 32'h1);
    drive(1'b0, 0, 1'b1, 32'h0, 32'h1234_5678);
    chk("t6_lerr_sticky", 32'(lerr[2]), 32'h1);
    readback();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
